// File: rtl/serial_add_sub_pkg.sv
// rtl/serial_add_sub_pkg.sv - shared encodings for the bit-serial adder/subtractor
package serial_add_sub_pkg;

  localparam int   SAS_DEFAULT_WIDTH = 32;
  localparam logic SAS_OP_ADD = 1'b0;
  localparam logic SAS_OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    SAS_IDLE = 2'd0,
    SAS_RUN  = 2'd1,
    SAS_DONE = 2'd2
  } sas_state_t;

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// rtl/serial_add_sub_full_adder.sv - single-bit full adder slice
module serial_add_sub_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial 2's-complement add/sub, LSB first
// One full-adder slice per clock; carry is held in a flop between bit steps.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int DATA_WIDTH = SAS_DEFAULT_WIDTH,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  OP,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] R,
  output logic                  CO,
  output logic                  OVF
);

  sas_state_t            state;
  logic [DATA_WIDTH-1:0] a_sr;
  logic [DATA_WIDTH-1:0] b_sr;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  carry;
  logic                  s_fa;
  logic                  co_fa;
  logic                  msb_step;

  serial_add_sub_full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (s_fa),
    .co (co_fa)
  );

  assign msb_step = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= SAS_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      R     <= '0;
      CO    <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      case (state)
        SAS_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
            a_sr  <= A;
            b_sr  <= B ^ {DATA_WIDTH{OP}};
            carry <= (OP == SAS_OP_SUB);
            cnt   <= '0;
            r_sr  <= '0;
            BUSY  <= 1'b1;
            state <= SAS_RUN;
          end
        end
        SAS_RUN: begin
          r_sr  <= {s_fa, r_sr[DATA_WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= co_fa;
          cnt   <= cnt + 1'b1;
          if (msb_step) begin
            // carry here is the carry into the MSB, needed for signed overflow.
            R     <= {s_fa, r_sr[DATA_WIDTH-1:1]};
            CO    <= co_fa;
            OVF   <= carry ^ co_fa;
            DONE  <= 1'b1;
            state <= SAS_DONE;
          end
        end
        SAS_DONE: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= SAS_IDLE;
        end
        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= SAS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - directed self-checking bench for serial_add_sub
module tb_serial_add_sub;

  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          OP;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          BUSY;
  logic          DONE;
  logic [DW-1:0] R;
  logic          CO;
  logic          OVF;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] r;
    logic          co;
    logic          ovf;
  } vec_t;

  vec_t vecs[9];

  serial_add_sub #(.DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .OP    (OP),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .R     (R),
    .CO    (CO),
    .OVF   (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic run_op(input string tag, input logic op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input bit inject, output time done_t);
    int            lat;
    int            busy_cnt;
    bit            held_bad;
    logic [DW-1:0] r_prev;
    lat      = 0;
    busy_cnt = 0;
    held_bad = 1'b0;
    done_t   = 0;
    r_prev   = R;
    START = 1'b1; OP = op; A = a; B = b;
    @(negedge CLK);
    START = 1'b0; OP = ~op; A = $urandom; B = $urandom;
    for (int n = 1; n <= 100; n++) begin
      if (BUSY) busy_cnt++;
      if (DONE) begin
        lat    = n;
        done_t = $time;
        break;
      end
      if (R !== r_prev) held_bad = 1'b1;
      if (inject && n == 10) begin
        START = 1'b1; OP = ~op; A = 32'h0000_0100; B = 32'h0000_0200;
      end else begin
        START = 1'b0;
      end
      @(negedge CLK);
    end
    START = 1'b0;
    check({tag, "_latency"}, lat, 33);
    check({tag, "_busy_cycles"}, busy_cnt, 33);
    check({tag, "_r_held"}, {31'b0, held_bad}, 0);
    @(negedge CLK);
    check({tag, "_done_pulse"}, {31'b0, DONE}, 0);
    check({tag, "_busy_low"}, {31'b0, BUSY}, 0);
  endtask

  initial begin
    time t1;
    time t2;
    bit  saw_done;

    vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};

    // Reset with START held high: reset must win.
    RST = 1'b1; START = 1'b1; OP = 1'b0; A = 32'h5; B = 32'h3;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_busy", {31'b0, BUSY}, 0);
    check("rst_done", {31'b0, DONE}, 0);
    check("rst_r", R, 0);
    check("rst_co", {31'b0, CO}, 0);
    check("rst_ovf", {31'b0, OVF}, 0);
    START = 1'b0;
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, t1);
      check($sformatf("v%0d_r", i), R, vecs[i].r);
      check($sformatf("v%0d_co", i), {31'b0, CO}, {31'b0, vecs[i].co});
      check($sformatf("v%0d_ovf", i), {31'b0, OVF}, {31'b0, vecs[i].ovf});
    end

    // START mid-run is ignored; R held at 0x7FFFFFFF until completion.
    run_op("inject", 1'b0, 32'h0000_0005, 32'h0000_0003, 1'b1, t1);
    check("inject_r", R, 32'h0000_0008);
    check("inject_co", {31'b0, CO}, 0);
    check("inject_ovf", {31'b0, OVF}, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
    end
    check("inject_not_queued", {31'b0, BUSY}, 0);

    // Back-to-back: second op starts in the first IDLE cycle after DONE.
    run_op("b2b_a", 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, t1);
    run_op("b2b_b", 1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0, t2);
    check("b2b_spacing", 32'((t2 - t1) / 10), 34);
    check("b2b_r", R, 32'h0000_0008);

    // Leave nonzero outputs in place, then abort mid-run with reset.
    run_op("pre_rst", 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, t1);
    START = 1'b1; OP = 1'b0; A = 32'h0000_0005; B = 32'h0000_0003;
    @(negedge CLK);
    START = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge CLK);
    end
    check("midrun_busy_before", {31'b0, BUSY}, 1);
    RST = 1'b1;
    #1;
    check("abort_busy", {31'b0, BUSY}, 0);
    check("abort_done", {31'b0, DONE}, 0);
    check("abort_r", R, 0);
    check("abort_co", {31'b0, CO}, 0);
    check("abort_ovf", {31'b0, OVF}, 0);
    @(negedge CLK);
    RST = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (DONE) saw_done = 1'b1;
    end
    check("abort_no_done", {31'b0, saw_done}, 0);
    run_op("post_rst", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, t1);
    check("post_rst_r", R, 32'h8000_0000);
    check("post_rst_co", {31'b0, CO}, 0);
    check("post_rst_ovf", {31'b0, OVF}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Bit-serial 2's-complement adder/subtractor. It drives a single FULL_ADDER slice once per clock, LSB first, with the carry held in a flip-flop between cycles. It sits directly downstream of FULL_ADDER and consumes its S/CO outputs every cycle. It gives the ALU an area-minimal add/sub path with a START/BUSY/DONE handshake.

Parameters:
DATA_WIDTH, 32, operand/result width in bits (must be >= 2).
CNT_WIDTH, 6, bit-counter width; must satisfy 2**CNT_WIDTH > DATA_WIDTH.

Ports:
CLK    input   1           system clock; all state changes on rising edge.
RST    input   1           asynchronous, active-high reset.
START  input   1           request; sampled only in IDLE.
OP     input   1           0 = add (A+B), 1 = subtract (A-B); sampled with START.
A      input   DATA_WIDTH  operand A; sampled with START.
B      input   DATA_WIDTH  operand B; sampled with START.
BUSY   output  1           high in RUN and DONE states.
DONE   output  1           one-cycle completion pulse.
R      output  DATA_WIDTH  result; registered, updated only at completion.
CO     output  1           carry out of MSB (subtract: 1 = no borrow, A >= B unsigned).
OVF    output  1           signed overflow = carry-into-MSB XOR carry-out-of-MSB.

Behaviour:
- Reset (asynchronous, RST=1): state=IDLE; BUSY=0, DONE=0, R=0, CO=0, OVF=0; shift registers, carry flop and counter cleared.
- States:
  - IDLE: on START=1 at edge t0:
    - a_sr<=A; b_sr<=B XOR {DATA_WIDTH{OP}}; carry<=OP; cnt<=0; r_sr<=0; go to RUN.
  - RUN: each edge drives FULL_ADDER with A=a_sr[0], B=b_sr[0], CI=carry.
    - r_sr<={S, r_sr[DATA_WIDTH-1:1]}; a_sr and b_sr shift right; carry<=CO_fa; cnt<=cnt+1.
    - At the step where cnt==DATA_WIDTH-1 (MSB step): capture msb_cin=carry, then go to DONE.
    - On that same edge load R<={S_fa, r_sr[DATA_WIDTH-1:1]}, CO<=CO_fa, OVF<=msb_cin XOR CO_fa.
  - DONE: DONE=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency: START sampled at t0; bit steps on edges t1..tDATA_WIDTH; DONE is high in the cycle after edge tDATA_WIDTH, i.e. DATA_WIDTH+1 cycles after START is sampled.
- BUSY rises in the cycle after START is accepted and falls on entry to IDLE.
- START in RUN or DONE is ignored; it is not queued.
- START asserted in the first IDLE cycle after DONE is accepted (back-to-back throughput = DATA_WIDTH+2 cycles).
- R/CO/OVF hold their last values until the next completion; they do not change during RUN. A, B and OP may change freely after acceptance.
- Arithmetic is modulo 2**DATA_WIDTH; CO and OVF are both always produced regardless of signedness interpretation.
- RST mid-operation aborts immediately: no DONE pulse, all outputs return to reset values.
- START and RST high together: reset wins.

Decomposition:
- Shared include file (project definitions header) holds:
  - OP encodings: SAS_OP_ADD=1'b0, SAS_OP_SUB=1'b1.
  - 2-bit state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default width constant of 32.
- Exactly one sub-module: a single FULL_ADDER instance forming the bit slice.
- Control FSM, counter and shift registers live in serial_add_sub.

Test Plan:
- ADD 0x00000005+0x00000003 -> R=0x00000008, CO=0, OVF=0; DONE high exactly 33 cycles after the START edge, for one cycle; BUSY high for 33 cycles.
- ADD 0xFFFFFFFF+0x00000001 -> R=0x00000000, CO=1, OVF=0; ADD 0x7FFFFFFF+0x00000001 -> R=0x80000000, CO=0, OVF=1.
- SUB 3-5 -> R=0xFFFFFFFE, CO=0, OVF=0; SUB 5-3 -> R=0x00000002, CO=1; SUB 0x80000000-0x00000001 -> R=0x7FFFFFFF, CO=1, OVF=1.
- Pulse START with different A/B at RUN cycle 10 -> ignored; result matches the first operands; R stays at the previous value until completion.
- Assert RST at RUN cycle 10 -> BUSY, DONE, R, CO and OVF go to 0 asynchronously; no DONE pulse; a following START completes normally.
- Assert START in the cycle after DONE -> accepted; second DONE arrives 34 cycles after the first.
